// File: rtl/btu_pkg.sv
// Shared decode constants and helpers for the branch target unit.
// Kind encoding is the 2-bit value presented on out_kind.
package btu_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } btu_kind_e;

  function automatic btu_kind_e decode_kind(input logic [31:0] instr);
    logic [2:0] f3;
    f3 = instr[14:12];
    decode_kind = KIND_NONE;
    case (instr[6:0])
      OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) decode_kind = KIND_BRANCH;
      OPC_JAL:    decode_kind = KIND_JAL;
      OPC_JALR:   if (f3 == F3_JALR) decode_kind = KIND_JALR;
      default:    decode_kind = KIND_NONE;
    endcase
  endfunction

  // x1 (ra) and x5 (t0) are the ABI link registers
  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/btu_ras.sv
// Circular return-address stack; the oldest entry is overwritten on overflow.
// Pop-then-push from one instruction replaces the current top in place.
module btu_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic            top_vld_o,
  output logic [XLEN-1:0] top_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   sp_q, sp_d, wr_idx;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_en, do_pop;

  assign top_vld_o = (cnt_q != '0);
  assign top_o     = mem_q[sp_q - PW'(1)];

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    do_pop = pop_i && (cnt_q != '0);
    if (do_pop && push_i) begin
      wr_en  = 1'b1;
      wr_idx = sp_q - PW'(1);
    end else if (do_pop) begin
      sp_d  = sp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (push_i) begin
      wr_en = 1'b1;
      sp_d  = sp_q + PW'(1);
      cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/branch_target_unit.sv
// Two-stage B/JAL/JALR target generator: stage 1 decodes, stage 2 holds the adds.
// Optional return-address stack is built when BTU_RAS_EN is defined.
module branch_target_unit
  import btu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit ALIGN_C   = 1'b0,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic            in_cmp_eq,
  input  logic            in_cmp_lt,
  input  logic            in_cmp_ltu,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_kind,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_link,
  output logic            out_misaligned,
  output logic            out_ras_hit,
  output logic [XLEN-1:0] out_ras_target
);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two and at least 2");
  end

  function automatic logic signed [XLEN-1:0] imm_of(input logic [31:0] ins, input btu_kind_e k);
    logic signed [12:0] imm_b;
    logic signed [20:0] imm_j;
    logic signed [11:0] imm_i;
    imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_i = ins[31:20];
    case (k)
      KIND_BRANCH: imm_of = {{(XLEN-13){imm_b[12]}}, imm_b};
      KIND_JAL:    imm_of = {{(XLEN-21){imm_j[20]}}, imm_j};
      default:     imm_of = {{(XLEN-12){imm_i[11]}}, imm_i};
    endcase
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt,
                                       input logic ltu);
    case (f3)
      F3_BEQ:  branch_cond = eq;
      F3_BNE:  branch_cond = !eq;
      F3_BLT:  branch_cond = lt;
      F3_BGE:  branch_cond = !lt;
      F3_BLTU: branch_cond = ltu;
      F3_BGEU: branch_cond = !ltu;
      default: branch_cond = 1'b0;
    endcase
  endfunction

  btu_kind_e              kind_in;
  logic                   vld_p1_q, vld_p2_q, adv_p1;
  btu_kind_e              kind_p1_q, kind_p2_q;
  logic signed [XLEN-1:0] imm_p1_q;
  logic [XLEN-1:0]        pc_p1_q, rs1_p1_q;
  logic [2:0]             f3_p1_q;
  logic                   eq_p1_q, lt_p1_q, ltu_p1_q;
  logic [XLEN-1:0]        seq_d, base_d, sum_d, tgt_d, tgt_p2_q, link_p2_q;
  logic                   taken_d, mis_d, taken_p2_q, mis_p2_q;

  assign kind_in  = decode_kind(in_instr);
  assign adv_p1   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p1;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (adv_p1)   vld_p2_q <= vld_p1_q;
    end
  end

  // Stage 1: decoded instruction and operands
  always_ff @(posedge clock) begin
    if (in_ready) begin
      kind_p1_q <= kind_in;
      imm_p1_q  <= imm_of(in_instr, kind_in);
      pc_p1_q   <= in_pc;
      rs1_p1_q  <= in_rs1;
      f3_p1_q   <= in_instr[14:12];
      eq_p1_q   <= in_cmp_eq;
      lt_p1_q   <= in_cmp_lt;
      ltu_p1_q  <= in_cmp_ltu;
    end
  end

  always_comb begin
    seq_d   = pc_p1_q + XLEN'(4);
    base_d  = (kind_p1_q == KIND_JALR) ? rs1_p1_q : pc_p1_q;
    sum_d   = base_d + $unsigned(imm_p1_q);
    taken_d = 1'b0;
    case (kind_p1_q)
      KIND_BRANCH:        taken_d = branch_cond(f3_p1_q, eq_p1_q, lt_p1_q, ltu_p1_q);
      KIND_JAL, KIND_JALR: taken_d = 1'b1;
      default:            taken_d = 1'b0;
    endcase
    tgt_d = taken_d ? sum_d : seq_d;
    if (kind_p1_q == KIND_JALR) tgt_d[0] = 1'b0;
    mis_d = taken_d && tgt_d[1] && !ALIGN_C;
  end

  // Stage 2: resolved target, link and alignment
  always_ff @(posedge clock) begin
    if (adv_p1) begin
      kind_p2_q  <= kind_p1_q;
      taken_p2_q <= taken_d;
      tgt_p2_q   <= tgt_d;
      link_p2_q  <= seq_d;
      mis_p2_q   <= mis_d;
    end
  end

  assign out_valid      = vld_p2_q;
  assign out_kind       = vld_p2_q ? kind_p2_q : KIND_NONE;
  assign out_taken      = vld_p2_q && taken_p2_q;
  assign out_target     = vld_p2_q ? tgt_p2_q : '0;
  assign out_link       = vld_p2_q ? link_p2_q : '0;
  assign out_misaligned = vld_p2_q && mis_p2_q;

`ifdef BTU_RAS_EN
  logic            push_in, pop_in, push_p1_q, pop_p1_q, push_p2_q, pop_p2_q;
  logic            out_hs, ras_top_vld;
  logic [XLEN-1:0] ras_top;

  assign push_in = (kind_in == KIND_JAL || kind_in == KIND_JALR) && is_link_reg(in_instr[11:7]);
  assign pop_in  = (kind_in == KIND_JALR) && is_link_reg(in_instr[19:15]) &&
                   (in_instr[19:15] != in_instr[11:7]);

  always_ff @(posedge clock) begin
    if (in_ready) begin
      push_p1_q <= push_in;
      pop_p1_q  <= pop_in;
    end
    if (adv_p1) begin
      push_p2_q <= push_p1_q;
      pop_p2_q  <= pop_p1_q;
    end
  end

  // Stack only moves when the consumer takes the instruction
  assign out_hs = vld_p2_q && out_ready;

  btu_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push_i    (out_hs && push_p2_q),
    .pop_i     (out_hs && pop_p2_q),
    .data_i    (link_p2_q),
    .top_vld_o (ras_top_vld),
    .top_o     (ras_top)
  );

  assign out_ras_hit    = vld_p2_q && pop_p2_q && ras_top_vld;
  assign out_ras_target = out_ras_hit ? ras_top : '0;
`else
  assign out_ras_hit    = 1'b0;
  assign out_ras_target = '0;
`endif

endmodule

// File: tb/tb_branch_target_unit.sv
// Randomized bench for branch_target_unit with a queue-based reference model;
// two instances cover both ALIGN_C settings.
module tb_branch_target_unit;

  localparam int RAS_D = 4;
`ifdef BTU_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    logic [1:0]  kind;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link;
    logic        mis0;
    logic        push;
    logic        pop;
    int          acc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic [31:0] in_pc, in_instr, in_rs1;

  logic        in_ready, out_valid, out_taken, out_mis, out_ras_hit;
  logic [1:0]  out_kind;
  logic [31:0] out_target, out_link, out_ras_target;

  logic        c_in_ready, c_out_valid, c_out_taken, c_out_mis, c_out_ras_hit;
  logic [1:0]  c_out_kind;
  logic [31:0] c_out_target, c_out_link, c_out_ras_target;

  branch_target_unit #(.XLEN(32), .ALIGN_C(1'b0), .RAS_DEPTH(RAS_D)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_cmp_eq(cmp_eq),
    .in_cmp_lt(cmp_lt), .in_cmp_ltu(cmp_ltu), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
    .out_misaligned(out_mis), .out_ras_hit(out_ras_hit), .out_ras_target(out_ras_target)
  );

  branch_target_unit #(.XLEN(32), .ALIGN_C(1'b1), .RAS_DEPTH(RAS_D)) dut_c (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_rs1(in_rs1), .in_cmp_eq(cmp_eq),
    .in_cmp_lt(cmp_lt), .in_cmp_ltu(cmp_ltu), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_kind(c_out_kind), .out_taken(c_out_taken), .out_target(c_out_target),
    .out_link(c_out_link), .out_misaligned(c_out_mis), .out_ras_hit(c_out_ras_hit),
    .out_ras_target(c_out_ras_target)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  exp_t        q[$];
  logic [31:0] ras[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ref_model(input logic [31:0] pc, input logic [31:0] instr,
                                     input logic [31:0] rs1, input logic e, input logic l,
                                     input logic lu);
    exp_t        r;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs;
    logic [31:0] immb, immj, immi;
    logic        cond;
    opc  = instr[6:0];
    f3   = instr[14:12];
    rd   = instr[11:7];
    rs   = instr[19:15];
    immb = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    immj = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    immi = {{20{instr[31]}}, instr[31:20]};
    r = '{kind: 2'd0, taken: 1'b0, target: pc + 32'd4, link: pc + 32'd4, mis0: 1'b0,
          push: 1'b0, pop: 1'b0, acc: 0};
    if (opc == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
      case (f3)
        3'd0:    cond = e;
        3'd1:    cond = !e;
        3'd4:    cond = l;
        3'd5:    cond = !l;
        3'd6:    cond = lu;
        default: cond = !lu;
      endcase
      r.kind  = 2'd1;
      r.taken = cond;
      if (cond) r.target = pc + immb;
    end else if (opc == 7'b1101111) begin
      r.kind   = 2'd2;
      r.taken  = 1'b1;
      r.target = pc + immj;
      r.push   = (rd == 5'd1 || rd == 5'd5);
    end else if (opc == 7'b1100111 && f3 == 3'd0) begin
      r.kind   = 2'd3;
      r.taken  = 1'b1;
      r.target = (rs1 + immi) & 32'hFFFF_FFFE;
      r.push   = (rd == 5'd1 || rd == 5'd5);
      r.pop    = (rs == 5'd1 || rs == 5'd5) && (rs != rd);
    end
    r.mis0 = r.taken && r.target[1];
    return r;
  endfunction

  always @(negedge clock) begin
    bit          exp_v, ir_e, hit_e;
    exp_t        h;
    logic [31:0] tgt_e;
    exp_v = 1'b0;
    if (q.size() > 0) exp_v = (cyc - q[0].acc) >= 2;
    ir_e = (q.size() < 2) || out_ready;
    if (chk_en) begin
      chk("out_valid", out_valid, exp_v);
      chk("out_valid_alignc", c_out_valid, exp_v);
      chk("in_ready", in_ready, ir_e);
      if (exp_v) begin
        h     = q[0];
        hit_e = RAS_ON && h.pop && (ras.size() > 0);
        tgt_e = hit_e ? ras[ras.size()-1] : 32'h0;
        chk("out_kind", out_kind, h.kind);
        chk("out_taken", out_taken, h.taken);
        chk("out_target", out_target, h.target);
        chk("out_link", out_link, h.link);
        chk("out_misaligned", out_mis, h.mis0);
        chk("out_misaligned_alignc", c_out_mis, 1'b0);
        chk("out_target_alignc", c_out_target, h.target);
        chk("out_ras_hit", out_ras_hit, hit_e);
        chk("out_ras_target", out_ras_target, tgt_e);
      end
    end
    if (exp_v && out_ready && !reset) begin
      h = q.pop_front();
      if (h.pop && ras.size() > 0) void'(ras.pop_back());
      if (h.push) begin
        ras.push_back(h.link);
        if (ras.size() > RAS_D) void'(ras.pop_front());
      end
    end
    if (reset) begin
      q.delete();
      ras.delete();
    end else if (flush) begin
      q.delete();
    end else if (in_valid && ir_e) begin
      h     = ref_model(in_pc, in_instr, in_rs1, cmp_eq, cmp_lt, cmp_ltu);
      h.acc = cyc;
      q.push_back(h);
    end
    cyc++;
  end

  task automatic send_wait(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rs1, input logic e, input logic l,
                           input logic lu, output bit got);
    @(posedge clock); #1;
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    in_pc = pc; in_instr = instr; in_rs1 = rs1; cmp_eq = e; cmp_lt = l; cmp_ltu = lu;
    @(posedge clock); #1;
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clock);
      got = out_valid;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [31:0] rs1, input logic e, input logic [1:0] kind,
                     input logic taken, input logic [31:0] tgt, input logic [31:0] link,
                     input logic mis0);
    bit got;
    send_wait(pc, instr, rs1, e, 1'b0, 1'b0, got);
    chk({nm, "_seen"}, got, 1'b1);
    if (got) begin
      chk({nm, "_kind"}, out_kind, kind);
      chk({nm, "_taken"}, out_taken, taken);
      chk({nm, "_target"}, out_target, tgt);
      chk({nm, "_link"}, out_link, link);
      chk({nm, "_mis"}, out_mis, mis0);
      chk({nm, "_mis_alignc"}, c_out_mis, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 1'b0);
    chk({nm, "_kind"}, out_kind, 2'd0);
    chk({nm, "_taken"}, out_taken, 1'b0);
    chk({nm, "_target"}, out_target, 32'h0);
    chk({nm, "_link"}, out_link, 32'h0);
    chk({nm, "_mis"}, out_mis, 1'b0);
    chk({nm, "_ras_hit"}, out_ras_hit, 1'b0);
    chk({nm, "_ras_target"}, out_ras_target, 32'h0);
    chk({nm, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic fill_two_hold_third();
    @(posedge clock); #1;
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_006F;
    in_pc = 32'h40;
    @(posedge clock); #1;
    in_pc = 32'h80;
    @(posedge clock); #1;
    in_pc = 32'hC0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 3) begin
      w[6:0] = 7'b1100011;
    end else if (sel <= 5) begin
      w[6:0] = 7'b1101111;
      w[11:7] = pick_reg();
    end else if (sel <= 8) begin
      w[6:0]   = 7'b1100111;
      w[11:7]  = pick_reg();
      w[19:15] = pick_reg();
      if ($urandom_range(0, 9) < 8) w[14:12] = 3'b000;
    end
    return w;
  endfunction

  initial begin
    bit got;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0; in_rs1 = '0; cmp_eq = 0; cmp_lt = 0; cmp_ltu = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clock);
    check_all_zero("reset_state");

    lit("beq_taken", 32'h100, 32'hFE20_8CE3, 32'h0, 1'b1, 2'd1, 1'b1, 32'hF8, 32'h104, 1'b0);
    lit("beq_not_taken", 32'h100, 32'hFE20_8CE3, 32'h0, 1'b0, 2'd1, 1'b0, 32'h104, 32'h104, 1'b0);
    lit("jal_fwd", 32'h1000, 32'h0010_00EF, 32'h0, 1'b0, 2'd2, 1'b1, 32'h1800, 32'h1004, 1'b0);
    lit("jal_wrap", 32'h0, 32'hFFDF_F06F, 32'h0, 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFC, 32'h4, 1'b0);
    lit("jalr_odd", 32'h500, 32'h0032_8067, 32'h2000, 1'b0, 2'd3, 1'b1, 32'h2002, 32'h504, 1'b1);
    lit("br_f3_010_none", 32'h700, 32'h0000_2063, 32'h0, 1'b1, 2'd0, 1'b0, 32'h704, 32'h704, 1'b0);
    lit("opc_other_none", 32'h800, 32'h0000_0013, 32'h0, 1'b1, 2'd0, 1'b0, 32'h804, 32'h804, 1'b0);

`ifdef BTU_RAS_EN
    pulse_reset();
    send_wait(32'h100, 32'h0000_00EF, 32'h0, 1'b0, 1'b0, 1'b0, got);
    chk("ras_call_seen", got, 1'b1);
    chk("ras_call_hit", out_ras_hit, 1'b0);
    send_wait(32'h300, 32'h0000_8067, 32'h104, 1'b0, 1'b0, 1'b0, got);
    chk("ras_ret_hit", out_ras_hit, 1'b1);
    chk("ras_ret_target", out_ras_target, 32'h104);
    for (int i = 0; i < 5; i++) send_wait(32'((i + 2) << 8), 32'h0000_00EF, 32'h0, 1'b0, 1'b0, 1'b0, got);
    for (int i = 0; i < 5; i++) begin
      send_wait(32'h900, 32'h0000_8067, 32'h0, 1'b0, 1'b0, 1'b0, got);
      chk("ras_deep_hit", out_ras_hit, (i < 4));
      chk("ras_deep_target", out_ras_target, (i < 4) ? 32'(((6 - i) << 8) + 4) : 32'h0);
    end
`endif

    // backpressure: two accepted, third held off, release preserves order
    fill_two_hold_third();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_hold_target", out_target, 32'h40);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_in_ready_release", in_ready, 1'b1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_second", out_target, 32'h80);
    @(negedge clock);
    chk("bp_third", out_target, 32'hC0);
    @(negedge clock);
    chk("bp_drained", out_valid, 1'b0);

    // flush with both stages full and a new offer
    fill_two_hold_third();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("flush_no_output", out_valid, 1'b0);
    end

    // reset mid-stream
    fill_two_hold_third();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    check_all_zero("midreset");

    for (int i = 0; i < 1500; i++) begin
      @(posedge clock); #1;
      flush     = ($urandom_range(0, 99) < 2);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_instr  = rand_instr();
      in_pc     = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      in_rs1    = $urandom;
      cmp_eq    = 1'($urandom_range(0, 1));
      cmp_lt    = 1'($urandom_range(0, 1));
      cmp_ltu   = 1'($urandom_range(0, 1));
      out_ready = flush ? 1'b0 : ($urandom_range(0, 99) < 75);
    end
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("final_drained", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised successor to the single-format branch offset generator. Decodes B-type, JAL and JALR control-transfer instructions.
- Builds the sign-extended immediate, resolves branch direction from comparator flags, and produces the next-PC target, link address and a misalignment flag.
- Two-stage valid/ready pipeline between decode and the PC-select/fetch redirect logic.

Parameters:
- XLEN, 32, address/data width; immediates sign-extended to XLEN.
- ALIGN_C, 0, 1 = 2-byte targets legal (compressed ISA); 0 = 4-byte alignment required.
- RAS_DEPTH, 4, return-address-stack entries; power of two, ≥2; used only with BTU_RAS_EN.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill both pipeline stages
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept
- in_pc  in  XLEN  PC of instruction
- in_instr  in  32  raw instruction
- in_rs1  in  XLEN  rs1 operand value
- in_cmp_eq, in_cmp_lt, in_cmp_ltu  in  1 each  comparator results for rs1 vs rs2
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_kind  out  2  0 NONE, 1 BRANCH, 2 JAL, 3 JALR
- out_taken  out  1  control transfer taken
- out_target  out  XLEN  next PC
- out_link  out  XLEN  pc+4
- out_misaligned  out  1  taken target violates alignment
- out_ras_hit  out  1  RAS prediction valid
- out_ras_target  out  XLEN  predicted return address

Behaviour:
- Reset: all stage valids 0. All outputs 0. RAS pointer and count 0.
- Stage 1 registers decoded kind, sign-extended immediate, pc, rs1 and flags. Stage 2 registers the arithmetic results. Latency from accept to out_valid is 2 cycles.
- in_ready = !s1_valid || s1 advances. s1 advances when !s2_valid || out_ready.
- Outputs are held stable while out_valid && !out_ready. No bubbles under continuous flow; throughput is 1 per cycle.
- flush has priority: both valids cleared next cycle, and any in_valid in the same cycle is dropped.
- Decode:
  - Opcode 1100011 gives BRANCH. funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. funct3 010/011 decode to NONE.
  - Opcode 1101111 gives JAL.
  - Opcode 1100111 with funct3 000 gives JALR.
  - Anything else gives NONE.
- Targets:
  - BRANCH taken, and JAL: pc+imm.
  - JALR: (rs1+imm) with bit0 cleared.
  - NONE, or BRANCH not taken: pc+4, out_taken 0.
  - JAL/JALR: out_taken always 1.
- All adds are modulo 2^XLEN; wrap-around is silent.
- out_link = pc+4 for every kind.
- out_misaligned = out_taken && target[1] && ALIGN_C==0. It never asserts for not-taken or NONE.

Optional Feature:
- Macro: BTU_RAS_EN.
- Defined: circular return-address stack.
  - Push link when JAL/JALR has rd ∈ {x1,x5}.
  - Pop when JALR has rs1 ∈ {x1,x5} and rs1≠rd.
  - Both apply (rs1≠rd, both link regs): pop then push.
  - out_ras_hit/out_ras_target reflect the top before update, and are presented with the popping instruction.
  - Update occurs only on output handshake (out_valid && out_ready), so flushed instructions never touch the RAS.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop on empty gives hit=0 and no pointer change.
- Undefined: out_ras_hit and out_ras_target tied 0, no RAS storage.

Decomposition:
- Package btu_pkg: opcode constants, funct3 codes, 2-bit kind encoding and its named values.
- Sub-module btu_ras: stack storage, pointer, count and push/pop arbitration. Instantiated only under BTU_RAS_EN.

Test Plan:
- BEQ x1,x2,-8 (0xFE208CE3), pc 0x100, cmp_eq=1 → 2 cycles later: kind 1, taken 1, target 0xF8, link 0x104. Same with cmp_eq=0 → taken 0, target 0x104.
- JAL x1,+2048 (0x001000EF), pc 0x1000 → kind 2, target 0x1800, link 0x1004. JAL x0,-4 (0xFFDFF06F), pc 0x0 → target 0xFFFFFFFC (wrap).
- JALR x0,3(x5) (0x00328067), rs1 0x2000 → target 0x2002, misaligned 1 (ALIGN_C=0); misaligned 0 with ALIGN_C=1.
- Backpressure: 3 back-to-back instructions, out_ready=0 for 4 cycles → in_ready falls after 2 accepted, outputs stable, order preserved on release.
- Flush with both stages full plus in_valid=1 → out_valid 0 next cycle, nothing emitted. reset mid-stream → all outputs 0 next cycle.
- BTU_RAS_EN: JAL x1 at pc 0x100, then JALR x0,0(x1) → ras_hit 1, ras_target 0x104. Five pushes with RAS_DEPTH 4, then five pops → first four hit newest-first, fifth hit 0.
